// File: rtl/mem_stage_access_unit.sv
// Memory-stage access unit: width-aware load/store over a req/ack memory port, plus branch/jump/jr redirect.
// Latency: 3 cycles minimum per access (IDLE detect, REQ, DONE); +1 per extra ack-wait cycle; redirect is combinational.
// Backpressure: Stall holds IF..EX/MEM from an aligned access request until DONE; REQ aborts after TIMEOUT cycles without MemAck.
module mem_stage_access_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [1:0]  DataMemChoice,
    input  logic [1:0]  RegisterLoadChoice,
    input  logic [31:0] ALUResult,
    input  logic [31:0] ReadData2,
    input  logic        Branch,
    input  logic        Zero,
    input  logic        Jump,
    input  logic        Jr,
    input  logic [31:0] BranchTargetAddress,
    input  logic [31:0] JumpTargetAddress,
    output logic        MemReq,
    output logic        MemWe,
    output logic [31:0] MemAddr,
    output logic [31:0] MemWData,
    output logic [3:0]  MemByteEn,
    input  logic        MemAck,
    input  logic [31:0] MemRData,
    output logic        Stall,
    output logic [31:0] LoadData,
    output logic        LoadValid,
    output logic        AlignErr,
    output logic        BusErr,
    output logic        Taken,
    output logic [31:0] TakenTarget
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Last REQ cycle index before the access is abandoned.
    localparam logic [7:0] TOUT_LAST = 8'(TIMEOUT - 1);

    logic [1:0]  state;
    logic [7:0]  toutCnt;
    logic [1:0]  accWidth;
    logic        accZext;
    logic [1:0]  accLo;

    logic        isAccess;
    logic        isHalf;
    logic        isByte;
    logic        misaligned;
    logic [31:0] storeData;
    logic [3:0]  storeBe;
    logic [7:0]  loadByte;
    logic [15:0] loadHalf;
    logic [31:0] extData;

    // Decode the incoming request: alignment check and lane-replicated store data/enables.
    always_comb begin
        isAccess   = MemRead | MemWrite;
        isHalf     = (DataMemChoice == 2'b01);
        isByte     = (DataMemChoice == 2'b10);
        misaligned = (isHalf & ALUResult[0]) |
                     (!isHalf & !isByte & (ALUResult[1:0] != 2'b00));
        storeData  = ReadData2;
        storeBe    = 4'b1111;
        if (isByte) begin
            storeData = {4{ReadData2[7:0]}};
            storeBe   = 4'b0001 << ALUResult[1:0];
        end else if (isHalf) begin
            storeData = {2{ReadData2[15:0]}};
            storeBe   = ALUResult[1] ? 4'b1100 : 4'b0011;
        end
    end

    // Pick the addressed byte/half from the returned word and extend it.
    always_comb begin
        case (accLo)
            2'b01:   loadByte = MemRData[15:8];
            2'b10:   loadByte = MemRData[23:16];
            2'b11:   loadByte = MemRData[31:24];
            default: loadByte = MemRData[7:0];
        endcase
        loadHalf = accLo[1] ? MemRData[31:16] : MemRData[15:0];
        case (accWidth)
            2'b10:   extData = accZext ? {24'b0, loadByte} : {{24{loadByte[7]}}, loadByte};
            2'b01:   extData = accZext ? {16'b0, loadHalf} : {{16{loadHalf[15]}}, loadHalf};
            default: extData = MemRData;
        endcase
    end

    // Access FSM with registered memory-port fields, load result and status pulses.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            toutCnt   <= 8'd0;
            accWidth  <= 2'b00;
            accZext   <= 1'b0;
            accLo     <= 2'b00;
            MemWe     <= 1'b0;
            MemAddr   <= 32'd0;
            MemWData  <= 32'd0;
            MemByteEn <= 4'd0;
            LoadData  <= 32'd0;
            LoadValid <= 1'b0;
            AlignErr  <= 1'b0;
            BusErr    <= 1'b0;
        end else begin
            LoadValid <= 1'b0;
            AlignErr  <= 1'b0;
            BusErr    <= 1'b0;
            case (state)
                IDLE: begin
                    if (isAccess) begin
                        if (misaligned) begin
                            AlignErr <= 1'b1;
                        end else begin
                            MemAddr   <= {ALUResult[31:2], 2'b00};
                            MemWData  <= storeData;
                            MemByteEn <= storeBe;
                            MemWe     <= MemWrite;
                            accWidth  <= DataMemChoice;
                            accZext   <= |RegisterLoadChoice;
                            accLo     <= ALUResult[1:0];
                            toutCnt   <= 8'd0;
                            state     <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (MemAck) begin
                        LoadData  <= extData;
                        LoadValid <= !MemWe;
                        state     <= DONE;
                    end else if (toutCnt == TOUT_LAST) begin
                        LoadData  <= 32'd0;
                        LoadValid <= !MemWe;
                        BusErr    <= 1'b1;
                        state     <= DONE;
                    end else begin
                        toutCnt <= toutCnt + 8'd1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Request/stall and redirect outputs; forced low while Reset is held.
    always_comb begin
        MemReq      = (state == REQ);
        Stall       = !Reset & (((state == IDLE) & isAccess & !misaligned) | (state == REQ));
        Taken       = !Reset & (Jr | Jump | (Branch & Zero));
        TakenTarget = 32'd0;
        if (!Reset) begin
            TakenTarget = (Jr | Jump) ? JumpTargetAddress : BranchTargetAddress;
        end
    end

endmodule

// File: tb/tb_mem_stage_access_unit.sv
module tb_mem_stage_access_unit;

    logic        Clk;
    logic        Reset;
    logic        MemRead, MemWrite;
    logic [1:0]  DataMemChoice, RegisterLoadChoice;
    logic [31:0] ALUResult, ReadData2;
    logic        Branch, Zero, Jump, Jr;
    logic [31:0] BranchTargetAddress, JumpTargetAddress;
    logic        MemReq, MemWe;
    logic [31:0] MemAddr, MemWData;
    logic [3:0]  MemByteEn;
    logic        MemAck;
    logic [31:0] MemRData;
    logic        Stall;
    logic [31:0] LoadData;
    logic        LoadValid, AlignErr, BusErr, Taken;
    logic [31:0] TakenTarget;

    int checks = 0;
    int passes = 0;

    // results of run_access
    int          stalls, reqc;
    logic [31:0] oA, oW, oL;
    logic [3:0]  oBe;
    logic        oWe, oV, oBE, dn;

    mem_stage_access_unit #(.TIMEOUT(4)) dut (
        .Clk(Clk), .Reset(Reset),
        .MemRead(MemRead), .MemWrite(MemWrite),
        .DataMemChoice(DataMemChoice), .RegisterLoadChoice(RegisterLoadChoice),
        .ALUResult(ALUResult), .ReadData2(ReadData2),
        .Branch(Branch), .Zero(Zero), .Jump(Jump), .Jr(Jr),
        .BranchTargetAddress(BranchTargetAddress), .JumpTargetAddress(JumpTargetAddress),
        .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemWData(MemWData),
        .MemByteEn(MemByteEn), .MemAck(MemAck), .MemRData(MemRData),
        .Stall(Stall), .LoadData(LoadData), .LoadValid(LoadValid),
        .AlignErr(AlignErr), .BusErr(BusErr), .Taken(Taken), .TakenTarget(TakenTarget)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Drives one access starting at posedge+2, acks in REQ cycle ackAt (-1 = never),
    // and returns what was observed; leaves the unit in DONE with inputs dropped.
    task automatic run_access(input logic rd, input logic wr, input logic [1:0] w,
                              input logic [1:0] ch, input logic [31:0] addr,
                              input logic [31:0] wd, input logic [31:0] rword,
                              input int ackAt);
        MemRead = rd; MemWrite = wr; DataMemChoice = w; RegisterLoadChoice = ch;
        ALUResult = addr; ReadData2 = wd;
        #1;
        stalls = (Stall === 1'b1) ? 1 : 0;
        reqc = 0; dn = 1'b0;
        oA = 'x; oW = 'x; oBe = 'x; oWe = 'x; oL = 'x; oV = 'x; oBE = 'x;
        for (int i = 0; i < 40 && !dn; i++) begin
            @(posedge Clk); #2;
            MemAck = 1'b0;
            if (MemReq === 1'b1) begin
                oA = MemAddr; oW = MemWData; oBe = MemByteEn; oWe = MemWe;
                if (reqc == ackAt) begin
                    MemAck = 1'b1; MemRData = rword;
                end
                reqc++;
                #1;
                if (Stall === 1'b1) stalls++;
            end else begin
                #1;
                dn = 1'b1;
                oL = LoadData; oV = LoadValid; oBE = BusErr;
                if (Stall === 1'b1) stalls++;
            end
        end
        MemRead = 1'b0; MemWrite = 1'b0; MemAck = 1'b0;
    endtask

    task automatic test_reset;
        Reset = 1'b1; MemRead = 1'b1; Jump = 1'b1; JumpTargetAddress = 32'h44;
        #3;
        checks++; if (MemReq !== 1'b0) $display("FAIL reset_memreq got %b want 0", MemReq); else passes++;
        checks++; if (Stall !== 1'b0) $display("FAIL reset_stall got %b want 0", Stall); else passes++;
        checks++; if (LoadData !== 32'h0) $display("FAIL reset_loaddata got %h want 0", LoadData); else passes++;
        checks++; if ({LoadValid, AlignErr, BusErr} !== 3'b000) $display("FAIL reset_pulses got %b want 000", {LoadValid, AlignErr, BusErr}); else passes++;
        checks++; if (Taken !== 1'b0) $display("FAIL reset_taken got %b want 0", Taken); else passes++;
        checks++; if (TakenTarget !== 32'h0) $display("FAIL reset_target got %h want 0", TakenTarget); else passes++;
        checks++; if (MemByteEn !== 4'h0) $display("FAIL reset_byteen got %b want 0000", MemByteEn); else passes++;
        MemRead = 1'b0; Jump = 1'b0; JumpTargetAddress = 32'h0;
        @(posedge Clk); #2;
        Reset = 1'b0;
    endtask

    task automatic test_word_load;
        run_access(1'b1, 1'b0, 2'b00, 2'b00, 32'h100, 32'h0, 32'h8001_7F80, 1);
        checks++; if (dn !== 1'b1) $display("FAIL wl_done got %b want 1", dn); else passes++;
        checks++; if (stalls != 3) $display("FAIL wl_stall_cycles got %0d want 3", stalls); else passes++;
        checks++; if (reqc != 2) $display("FAIL wl_req_cycles got %0d want 2", reqc); else passes++;
        checks++; if (oA !== 32'h100) $display("FAIL wl_addr got %h want 00000100", oA); else passes++;
        checks++; if (oBe !== 4'b1111) $display("FAIL wl_byteen got %b want 1111", oBe); else passes++;
        checks++; if (oWe !== 1'b0) $display("FAIL wl_we got %b want 0", oWe); else passes++;
        checks++; if (oL !== 32'h8001_7F80) $display("FAIL wl_data got %h want 80017f80", oL); else passes++;
        checks++; if (oV !== 1'b1) $display("FAIL wl_valid got %b want 1", oV); else passes++;
        @(posedge Clk); #3;
        checks++; if (LoadValid !== 1'b0) $display("FAIL wl_valid_width got %b want 0", LoadValid); else passes++;
        checks++; if (Stall !== 1'b0) $display("FAIL wl_idle_stall got %b want 0", Stall); else passes++;
        @(posedge Clk); #2;
    endtask

    task automatic test_byte_load;
        run_access(1'b1, 1'b0, 2'b10, 2'b00, 32'h103, 32'h0, 32'h8012_3456, 0);
        checks++; if (oL !== 32'hFFFF_FF80) $display("FAIL bl_sext got %h want ffffff80", oL); else passes++;
        checks++; if (stalls != 2) $display("FAIL bl_min_stall got %0d want 2", stalls); else passes++;
        @(posedge Clk); #2;
        run_access(1'b1, 1'b0, 2'b10, 2'b01, 32'h103, 32'h0, 32'h8012_3456, 0);
        checks++; if (oL !== 32'h0000_0080) $display("FAIL bl_zext got %h want 00000080", oL); else passes++;
        @(posedge Clk); #2;
        run_access(1'b1, 1'b0, 2'b10, 2'b00, 32'h101, 32'h0, 32'h0000_7F00, 0);
        checks++; if (oL !== 32'h0000_007F) $display("FAIL bl_lane1 got %h want 0000007f", oL); else passes++;
        @(posedge Clk); #2;
    endtask

    task automatic test_store;
        run_access(1'b0, 1'b1, 2'b01, 2'b00, 32'h202, 32'h0000_ABCD, 32'h0, 0);
        checks++; if (oA !== 32'h200) $display("FAIL hs_addr got %h want 00000200", oA); else passes++;
        checks++; if (oW !== 32'hABCD_ABCD) $display("FAIL hs_wdata got %h want abcdabcd", oW); else passes++;
        checks++; if (oBe !== 4'b1100) $display("FAIL hs_byteen got %b want 1100", oBe); else passes++;
        checks++; if (oWe !== 1'b1) $display("FAIL hs_we got %b want 1", oWe); else passes++;
        checks++; if (oV !== 1'b0) $display("FAIL hs_novalid got %b want 0", oV); else passes++;
        @(posedge Clk); #2;
        run_access(1'b0, 1'b1, 2'b10, 2'b00, 32'h201, 32'h1234_565A, 32'h0, 0);
        checks++; if (oW !== 32'h5A5A_5A5A) $display("FAIL bs_wdata got %h want 5a5a5a5a", oW); else passes++;
        checks++; if (oBe !== 4'b0010) $display("FAIL bs_byteen got %b want 0010", oBe); else passes++;
        @(posedge Clk); #2;
        run_access(1'b1, 1'b1, 2'b11, 2'b00, 32'h300, 32'hDEAD_BEEF, 32'h0, 0);
        checks++; if (oWe !== 1'b1) $display("FAIL rw_is_write got %b want 1", oWe); else passes++;
        checks++; if (oW !== 32'hDEAD_BEEF) $display("FAIL rw_wdata got %h want deadbeef", oW); else passes++;
        @(posedge Clk); #2;
    endtask

    task automatic test_align;
        MemRead = 1'b1; DataMemChoice = 2'b00; ALUResult = 32'h101;
        #1;
        checks++; if (Stall !== 1'b0) $display("FAIL al_stall_detect got %b want 0", Stall); else passes++;
        @(posedge Clk); #2;
        MemRead = 1'b0;
        #1;
        checks++; if (AlignErr !== 1'b1) $display("FAIL al_pulse got %b want 1", AlignErr); else passes++;
        checks++; if (MemReq !== 1'b0) $display("FAIL al_noreq got %b want 0", MemReq); else passes++;
        @(posedge Clk); #3;
        checks++; if (AlignErr !== 1'b0) $display("FAIL al_pulse_width got %b want 0", AlignErr); else passes++;
        checks++; if (MemReq !== 1'b0) $display("FAIL al_noreq2 got %b want 0", MemReq); else passes++;
        @(posedge Clk); #2;
        run_access(1'b1, 1'b0, 2'b01, 2'b00, 32'h102, 32'h0, 32'h9ABC_1234, 0);
        checks++; if (reqc != 1) $display("FAIL hl_issued got %0d want 1", reqc); else passes++;
        checks++; if (oL !== 32'hFFFF_9ABC) $display("FAIL hl_data got %h want ffff9abc", oL); else passes++;
        @(posedge Clk); #2;
    endtask

    task automatic test_timeout;
        run_access(1'b1, 1'b0, 2'b00, 2'b00, 32'h400, 32'h0, 32'h1234_5678, -1);
        checks++; if (dn !== 1'b1) $display("FAIL to_done got %b want 1", dn); else passes++;
        checks++; if (reqc != 4) $display("FAIL to_req_cycles got %0d want 4", reqc); else passes++;
        checks++; if (oBE !== 1'b1) $display("FAIL to_buserr got %b want 1", oBE); else passes++;
        checks++; if (oL !== 32'h0) $display("FAIL to_loaddata got %h want 0", oL); else passes++;
        @(posedge Clk); #2;
        checks++; if (BusErr !== 1'b0) $display("FAIL to_pulse_width got %b want 0", BusErr); else passes++;
        MemAck = 1'b1; MemRData = 32'hFFFF_FFFF;
        @(posedge Clk); #2;
        MemAck = 1'b0;
        #1;
        checks++; if ({MemReq, LoadValid, Stall} !== 3'b000) $display("FAIL to_late_ack got %b want 000", {MemReq, LoadValid, Stall}); else passes++;
        checks++; if (LoadData !== 32'h0) $display("FAIL to_late_data got %h want 0", LoadData); else passes++;
        @(posedge Clk); #2;
    endtask

    task automatic test_control_flow;
        BranchTargetAddress = 32'h80; JumpTargetAddress = 32'h40;
        Jr = 1'b1; Jump = 1'b1; Branch = 1'b1; Zero = 1'b1;
        #1;
        checks++; if ({Taken, TakenTarget} !== {1'b1, 32'h40}) $display("FAIL cf_all got %b/%h want 1/00000040", Taken, TakenTarget); else passes++;
        Jr = 1'b0; Jump = 1'b0;
        #1;
        checks++; if ({Taken, TakenTarget} !== {1'b1, 32'h80}) $display("FAIL cf_branch got %b/%h want 1/00000080", Taken, TakenTarget); else passes++;
        Zero = 1'b0;
        #1;
        checks++; if (Taken !== 1'b0) $display("FAIL cf_not_taken got %b want 0", Taken); else passes++;
        Jr = 1'b1;
        #1;
        checks++; if ({Taken, TakenTarget} !== {1'b1, 32'h40}) $display("FAIL cf_jr got %b/%h want 1/00000040", Taken, TakenTarget); else passes++;
        Jr = 1'b0; Branch = 1'b0;
        @(posedge Clk); #2;
    endtask

    task automatic test_reset_mid_req;
        MemRead = 1'b1; DataMemChoice = 2'b00; ALUResult = 32'h500;
        Jump = 1'b1; JumpTargetAddress = 32'h44;
        @(posedge Clk); #2;
        #1;
        checks++; if (MemReq !== 1'b1) $display("FAIL rm_in_req got %b want 1", MemReq); else passes++;
        Reset = 1'b1;
        #1;
        checks++; if ({MemReq, Stall, Taken} !== 3'b000) $display("FAIL rm_outputs got %b want 000", {MemReq, Stall, Taken}); else passes++;
        checks++; if (MemAddr !== 32'h0) $display("FAIL rm_addr got %h want 0", MemAddr); else passes++;
        checks++; if (TakenTarget !== 32'h0) $display("FAIL rm_target got %h want 0", TakenTarget); else passes++;
        MemRead = 1'b0; Jump = 1'b0;
        @(posedge Clk); #2;
        Reset = 1'b0; MemAck = 1'b1; MemRData = 32'h5555_5555;
        @(posedge Clk); #2;
        MemAck = 1'b0;
        #1;
        checks++; if ({MemReq, LoadValid, Stall} !== 3'b000) $display("FAIL rm_stale_ack got %b want 000", {MemReq, LoadValid, Stall}); else passes++;
        @(posedge Clk); #2;
        run_access(1'b1, 1'b0, 2'b00, 2'b00, 32'h600, 32'h0, 32'h0BAD_F00D, 0);
        checks++; if (reqc != 1 || stalls != 2) $display("FAIL rm_fresh_access got req=%0d stall=%0d want req=1 stall=2", reqc, stalls); else passes++;
        checks++; if (oL !== 32'h0BAD_F00D) $display("FAIL rm_fresh_data got %h want 0badf00d", oL); else passes++;
        @(posedge Clk); #2;
    endtask

    initial begin
        MemRead = 0; MemWrite = 0; DataMemChoice = 0; RegisterLoadChoice = 0;
        ALUResult = 0; ReadData2 = 0; Branch = 0; Zero = 0; Jump = 0; Jr = 0;
        BranchTargetAddress = 0; JumpTargetAddress = 0; MemAck = 0; MemRData = 0;
        Reset = 1;
        test_reset;
        test_word_load;
        test_byte_load;
        test_store;
        test_align;
        test_timeout;
        test_control_flow;
        test_reset_mid_req;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
